debounce_multi: RTL

- Parametrised N-channel push-button debouncer for the pong input path (paddle up/down, serve, reset-game buttons).
- Runs entirely on the system clock: an internal prescaler produces a sample-enable tick, with no derived clock.
- Per channel it provides:
  - symmetric press/release filtering;
  - one-cycle rise and fall pulses;
  - an optional auto-repeat pulse stream for held paddle buttons.

---
 rtl/debounce_multi_pkg.sv | 24 ++
 rtl/debounce_chan.sv | 128 ++++++++++++
 rtl/debounce_multi.sv | 67 ++++++
 3 files changed

// File: rtl/debounce_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi_pkg
//  Description : Shared pong constants (clock rate, 1 ms tick divider,
//                button channel indices) and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_multi_pkg;

   localparam int CLK_HZ       = 50_000_000;
   localparam int TICK_DIV_1MS = CLK_HZ / 1000;

   localparam int BTN_P1_UP = 0;
   localparam int BTN_P1_DN = 1;
   localparam int BTN_P2_UP = 2;
   localparam int BTN_P2_DN = 3;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : debounce_multi_pkg
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_chan
//  Description : One button channel: two-flop synchronizer, symmetric
//                stability filter evaluated on the shared sample tick,
//                registered rise/fall pulses and optional auto-repeat.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
   import debounce_multi_pkg::*;
#(
   parameter int STABLE_TICKS = 8,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
)(
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic button,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rpt
);

   localparam int            CW       = width_of(STABLE_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q,  cnt_d;
   logic          level_q, level_d;
   logic          rise_q,  rise_d;
   logic          fall_q,  fall_d;
   logic          rpt_q,   rpt_d;

   // Shift the raw level into the two-stage synchronizer.
   always_comb begin
      sync_d = {sync_q[0], button};
   end

   // Stability filter: a change is accepted after STABLE_TICKS consecutive
   // disagreeing samples; any agreeing sample restarts qualification.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (tick) begin
         if (sync_q[1] == level_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            level_d = sync_q[1];
            cnt_d   = '0;
            rise_d  = sync_q[1];
            fall_d  = ~sync_q[1];
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   generate
      if (REPEAT_DELAY > 0) begin : g_repeat
         localparam int            RW        = width_of(REPEAT_DELAY);
         // rcnt reaches REPEAT_DELAY on the tick where it would step past this value.
         localparam logic [RW-1:0] RCNT_DUE  = RW'(REPEAT_DELAY - 1);
         localparam logic [RW-1:0] RCNT_LOAD = RW'((REPEAT_DELAY > REPEAT_RATE) ?
                                                   (REPEAT_DELAY - REPEAT_RATE) : 0);
         localparam logic [RW-1:0] RCNT_ONE  = RW'(1);

         logic [RW-1:0] rcnt_q, rcnt_d;

         // Repeat timer: counts ticks while held; an accepted release wins
         // over a repeat that falls due on the same tick.
         always_comb begin
            rcnt_d = rcnt_q;
            rpt_d  = rise_d;
            if (!level_q) begin
               rcnt_d = '0;
            end else if (tick) begin
               if (fall_d) begin
                  rcnt_d = '0;
               end else if (rcnt_q == RCNT_DUE) begin
                  rpt_d  = 1'b1;
                  rcnt_d = RCNT_LOAD;
               end else begin
                  rcnt_d = rcnt_q + RCNT_ONE;
               end
            end
         end

         // Repeat timer register.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) rcnt_q <= '0;
            else     rcnt_q <= rcnt_d;
         end
      end else begin : g_no_repeat
         assign rpt_d = rise_d;
      end
   endgenerate

   // Channel state and output pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         rpt_q   <= rpt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;
   assign rpt   = rpt_q;

endmodule : debounce_chan
`default_nettype wire

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : N-channel push-button debouncer. A shared prescaler makes
//                a one-clock sample tick every TICK_DIV clocks; each channel
//                filters, edge-detects and auto-repeats independently.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi
   import debounce_multi_pkg::*;
#(
   parameter int N            = 4,
   parameter int TICK_DIV     = TICK_DIV_1MS,
   parameter int STABLE_TICKS = 8,
   parameter int REPEAT_DELAY = 250,
   parameter int REPEAT_RATE  = 50
)(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] button,
   output logic [N-1:0] level,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] rpt
);

   localparam int            PW       = width_of(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE  = PW'(1);

   logic [PW-1:0] pre_q, pre_d;
   logic          w_tick;

   assign w_tick = (pre_q == PRE_LAST);

   // Prescaler: wraps at TICK_DIV-1, which is also the tick cycle.
   always_comb begin
      pre_d = w_tick ? '0 : (pre_q + PRE_ONE);
   end

   // Prescaler register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

   generate
      for (genvar i = 0; i < N; i++) begin : g_chan
         debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
         ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .tick   (w_tick),
            .button (button[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .rpt    (rpt[i])
         );
      end
   endgenerate

endmodule : debounce_multi
`default_nettype wire
